// File: rtl/rs_decoder.sv
// RS(7,5) single-symbol-correcting decoder over GF(8), primitive poly x^3+x+1.
// Correction is combinational; the error/uncorrectable flags are registered.
module rs_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [20:0] codeword,
  output logic [20:0] corrected,
  output logic        err_detected,
  output logic        uncorrectable
);

  localparam logic [2:0] ALPHA   = 3'b010;
  localparam logic [2:0] ALPHA_2 = 3'b100;

  // Symbols store the x^0 coefficient in bit 2; the arithmetic below works on
  // the natural ordering (bit k = x^k), so symbols are bit-reversed on entry.
  function automatic logic [2:0] sym_to_poly(input logic [2:0] s);
    return {s[0], s[1], s[2]};
  endfunction

  function automatic logic [2:0] gf_mul(input logic [2:0] x, input logic [2:0] y);
    logic [4:0] p;
    p = '0;
    for (int i = 0; i < 3; i++) begin
      if (y[i]) p = p ^ ({2'b00, x} << i);
    end
    if (p[4]) p = p ^ 5'b10110;
    if (p[3]) p = p ^ 5'b01011;
    return p[2:0];
  endfunction

  function automatic logic [2:0] gf_log(input logic [2:0] v);
    logic [2:0] l;
    case (v)
      3'd1:    l = 3'd0;
      3'd2:    l = 3'd1;
      3'd4:    l = 3'd2;
      3'd3:    l = 3'd3;
      3'd6:    l = 3'd4;
      3'd7:    l = 3'd5;
      3'd5:    l = 3'd6;
      default: l = 3'd0;
    endcase
    return l;
  endfunction

  function automatic logic [2:0] gf_exp(input logic [2:0] l);
    logic [2:0] v;
    case (l)
      3'd0:    v = 3'd1;
      3'd1:    v = 3'd2;
      3'd2:    v = 3'd4;
      3'd3:    v = 3'd3;
      3'd4:    v = 3'd6;
      3'd5:    v = 3'd7;
      3'd6:    v = 3'd5;
      default: v = 3'd1;
    endcase
    return v;
  endfunction

  // Inputs never exceed 20, so two conditional subtractions suffice.
  function automatic logic [2:0] mod7(input logic [4:0] x);
    logic [4:0] t;
    t = x;
    if (t >= 5'd14)     t = t - 5'd14;
    else if (t >= 5'd7) t = t - 5'd7;
    return t[2:0];
  endfunction

  logic [2:0]  sym_poly [7];
  logic [2:0]  h1 [8];
  logic [2:0]  h2 [8];
  logic [2:0]  s1;
  logic [2:0]  s2;
  logic [2:0]  log_s1;
  logic [2:0]  log_s2;
  logic [2:0]  err_loc;
  logic [2:0]  mag_log;
  logic [2:0]  mag_sym;
  logic        syndrome_nz;
  logic        correctable;
  logic [20:0] fixed_word;
  logic        err_detected_reg;
  logic        uncorrectable_reg;

  // Horner evaluation of r(a) and r(a^2), highest-order symbol first.
  assign h1[7] = '0;
  assign h2[7] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_syndrome
      assign sym_poly[gi] = sym_to_poly(codeword[3*gi +: 3]);
      assign h1[gi] = gf_mul(h1[gi+1], ALPHA) ^ sym_poly[gi];
      assign h2[gi] = gf_mul(h2[gi+1], ALPHA_2) ^ sym_poly[gi];
    end
  endgenerate

  assign s1 = h1[0];
  assign s2 = h2[0];

  assign syndrome_nz = (s1 != 3'd0) || (s2 != 3'd0);
  assign correctable = (s1 != 3'd0) && (s2 != 3'd0);

  // Location a^j = S2/S1 and magnitude e = S1^2/S2, done in the log domain.
  assign log_s1  = gf_log(s1);
  assign log_s2  = gf_log(s2);
  assign err_loc = mod7({2'b00, log_s2} + 5'd7 - {2'b00, log_s1});
  assign mag_log = mod7({1'b0, log_s1, 1'b0} + 5'd7 - {2'b00, log_s2});
  assign mag_sym = sym_to_poly(gf_exp(mag_log));

  generate
    for (gi = 0; gi < 7; gi++) begin : g_correct
      assign fixed_word[3*gi +: 3] = (correctable && (err_loc == 3'(gi)))
                                   ? (codeword[3*gi +: 3] ^ mag_sym)
                                   : codeword[3*gi +: 3];
    end
  endgenerate

  assign corrected = reset ? 21'd0 : fixed_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_detected_reg  <= 1'b0;
      uncorrectable_reg <= 1'b0;
    end else begin
      err_detected_reg  <= syndrome_nz;
      uncorrectable_reg <= syndrome_nz && !correctable;
    end
  end

  assign err_detected  = err_detected_reg;
  assign uncorrectable = uncorrectable_reg;

endmodule

// File: tb/tb_rs_decoder.sv
// Randomised self-checking bench for rs_decoder against a brute-force
// single-error-search reference decoder.
module tb_rs_decoder;

  localparam logic [20:0] CLEAN   = 21'b000_100_111_001_001_101_110;
  localparam logic [20:0] P0_FLIP = 21'b000_100_111_001_001_101_010;
  localparam logic [20:0] S5_FLIP = 21'b000_101_111_001_001_101_110;
  localparam logic [20:0] UNC     = 21'b000_100_111_001_001_001_100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [20:0] codeword = CLEAN;
  logic [20:0] corrected;
  logic        err_detected;
  logic        uncorrectable;

  int n_checks = 0;
  int n_fail   = 0;

  rs_decoder dut (
    .clk           (clk),
    .reset         (reset),
    .codeword      (codeword),
    .corrected     (corrected),
    .err_detected  (err_detected),
    .uncorrectable (uncorrectable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: plain polynomial multiply mod x^3+x+1, natural bit order.
  function automatic int gmul(input int a, input int b);
    int r;
    r = 0;
    for (int i = 0; i < 3; i++) if (((b >> i) & 1) != 0) r = r ^ (a << i);
    for (int k = 4; k >= 3; k--) if (((r >> k) & 1) != 0) r = r ^ (11 << (k - 3));
    return r;
  endfunction

  function automatic int rev3(input int s);
    return ((s & 1) << 2) | (s & 2) | ((s >> 2) & 1);
  endfunction

  // r(a^k) as the plain sum of r_i * (a^k)^i.
  function automatic int syn(input logic [20:0] w, input int k);
    int ak, p, acc;
    ak  = (k == 1) ? 2 : 4;
    p   = 1;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      acc = acc ^ gmul(rev3(int'(w[3*i +: 3])), p);
      p   = gmul(p, ak);
    end
    return acc;
  endfunction

  function automatic logic is_codeword(input logic [20:0] w);
    return (syn(w, 1) == 0) && (syn(w, 2) == 0);
  endfunction

  // Decode by searching all 49 single-symbol error patterns.
  task automatic model(input logic [20:0] w, output logic [20:0] corr,
                       output logic err, output logic unc);
    logic found;
    logic [20:0] cand;
    err   = !is_codeword(w);
    found = 1'b0;
    corr  = w;
    if (err) begin
      for (int j = 0; j < 7; j++) begin
        for (int e = 1; e < 8; e++) begin
          cand = w ^ (21'(e) << (3 * j));
          if (!found && is_codeword(cand)) begin
            found = 1'b1;
            corr  = cand;
          end
        end
      end
    end
    unc = err && !found;
  endtask

  function automatic logic [20:0] make_valid();
    logic [14:0] msg;
    logic [20:0] w;
    msg = 15'($urandom);
    w   = {msg, 6'd0};
    for (int p = 0; p < 64; p++) begin
      if (is_codeword({msg, 6'(p)})) w = {msg, 6'(p)};
    end
    return w;
  endfunction

  task automatic drive_and_check(input logic [20:0] w);
    logic [20:0] mc;
    logic me, mu;
    model(w, mc, me, mu);
    @(negedge clk);
    codeword = w;
    #1;
    check("corrected", 32'(corrected), 32'(mc));
    @(posedge clk);
    #1;
    check("err_detected", 32'(err_detected), 32'(me));
    check("uncorrectable", 32'(uncorrectable), 32'(mu));
  endtask

  initial begin
    logic [20:0] valid;
    logic [20:0] w;

    #1 reset = 1'b1;
    #2;
    check("reset_corrected", 32'(corrected), 32'd0);
    check("reset_err", 32'(err_detected), 32'd0);
    check("reset_unc", 32'(uncorrectable), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("release_corrected", 32'(corrected), 32'(CLEAN));
    @(posedge clk);
    #1;
    check("release_err", 32'(err_detected), 32'd0);

    drive_and_check(CLEAN);
    check("clean_corr", 32'(corrected), 32'(CLEAN));
    check("clean_err", 32'(err_detected), 32'd0);
    drive_and_check(P0_FLIP);
    check("p0_corr", 32'(corrected), 32'(CLEAN));
    check("p0_err", 32'(err_detected), 32'd1);
    check("p0_unc", 32'(uncorrectable), 32'd0);
    drive_and_check(S5_FLIP);
    check("s5_corr", 32'(corrected), 32'(CLEAN));
    check("s5_err", 32'(err_detected), 32'd1);
    drive_and_check(UNC);
    check("unc_corr", 32'(corrected), 32'(UNC));
    check("unc_err", 32'(err_detected), 32'd1);
    check("unc_unc", 32'(uncorrectable), 32'd1);

    // Asynchronous reset in the middle of the high phase, away from any edge.
    #2 reset = 1'b1;
    #1;
    check("midreset_corr", 32'(corrected), 32'd0);
    check("midreset_err", 32'(err_detected), 32'd0);
    check("midreset_unc", 32'(uncorrectable), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrelease_corr", 32'(corrected), 32'(UNC));
    @(posedge clk);
    #1;
    check("midrelease_err", 32'(err_detected), 32'd1);
    check("midrelease_unc", 32'(uncorrectable), 32'd1);

    valid = make_valid();
    for (int j = 0; j < 7; j++) begin
      for (int e = 1; e < 8; e++) begin
        w = valid ^ (21'(e) << (3 * j));
        drive_and_check(w);
        check("sweep_corr", 32'(corrected), 32'(valid));
      end
    end

    for (int n = 0; n < 150; n++) drive_and_check(21'($urandom));

    for (int n = 0; n < 40; n++) begin
      valid = make_valid();
      w = valid ^ (21'($urandom_range(1, 7)) << (3 * $urandom_range(0, 6)))
                ^ (21'($urandom_range(1, 7)) << (3 * $urandom_range(0, 6)));
      drive_and_check(w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
